// File: rtl/shift_arb_ctrl.sv
// Two-requester round-robin front end for a registered shift unit.
// Each operation runs IDLE -> ISSUE -> WAIT -> DONE; every output comes straight from a flop.
module shift_arb_ctrl #(
  parameter int in_width  = 8,
  parameter int out_width = 16,
  parameter int TIMEOUT   = 4
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 REQ0,
  input  logic                 REQ1,
  input  logic [1:0]           FUN0,
  input  logic [1:0]           FUN1,
  input  logic [in_width-1:0]  A0,
  input  logic [in_width-1:0]  B0,
  input  logic [in_width-1:0]  A1,
  input  logic [in_width-1:0]  B1,
  output logic                 GNT0,
  output logic                 GNT1,
  output logic                 DONE0,
  output logic                 DONE1,
  output logic [out_width-1:0] RESULT,
  output logic                 ERR,
  output logic                 BUSY,
  output logic [in_width-1:0]  SU_A,
  output logic [in_width-1:0]  SU_B,
  output logic [1:0]           SU_FUN,
  output logic                 SU_EN,
  input  logic [out_width-1:0] SU_OUT,
  input  logic                 SU_FLAG
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int          CNT_W    = 4;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                 state_q;
  logic                   win_q;
  logic                   last_q;
  logic [CNT_W-1:0]       wait_cnt_q;
  logic                   gnt0_q, gnt1_q;
  logic                   done0_q, done1_q;
  logic [out_width-1:0]   result_q;
  logic                   err_q;
  logic                   busy_q;
  logic [in_width-1:0]    su_a_q, su_b_q;
  logic [1:0]             su_fun_q;
  logic                   su_en_q;

  logic                   win_d;
  logic [in_width-1:0]    a_d, b_d;
  logic [1:0]             fun_d;

  // Round-robin: on contention the requester not granted last wins.
  always_comb begin
    win_d = REQ1;
    if (REQ0 && REQ1) win_d = ~last_q;
    a_d   = win_d ? A1   : A0;
    b_d   = win_d ? B1   : B0;
    fun_d = win_d ? FUN1 : FUN0;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      win_q      <= 1'b0;
      last_q     <= 1'b1;
      wait_cnt_q <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      result_q   <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      su_a_q     <= '0;
      su_b_q     <= '0;
      su_fun_q   <= '0;
      su_en_q    <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here; a later non-blocking assignment
      // in the same block overrides the default, so only the asserting states set them.
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      su_a_q   <= '0;
      su_b_q   <= '0;
      su_fun_q <= '0;
      su_en_q  <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (REQ0 || REQ1) begin
            win_q    <= win_d;
            last_q   <= win_d;
            su_a_q   <= a_d;
            su_b_q   <= b_d;
            su_fun_q <= fun_d;
            su_en_q  <= 1'b1;
            gnt0_q   <= ~win_d;
            gnt1_q   <= win_d;
            busy_q   <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (SU_FLAG) begin
            result_q <= SU_OUT;
            done0_q  <= ~win_q;
            done1_q  <= win_q;
            state_q  <= ST_DONE;
          end else if (wait_cnt_q == WAIT_LAST) begin
            // Abort: the result register stays at its cleared default and ERR flags it.
            err_q   <= 1'b1;
            done0_q <= ~win_q;
            done1_q <= win_q;
            state_q <= ST_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign GNT0   = gnt0_q;
  assign GNT1   = gnt1_q;
  assign DONE0  = done0_q;
  assign DONE1  = done1_q;
  assign RESULT = result_q;
  assign ERR    = err_q;
  assign BUSY   = busy_q;
  assign SU_A   = su_a_q;
  assign SU_B   = su_b_q;
  assign SU_FUN = su_fun_q;
  assign SU_EN  = su_en_q;

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Bench for shift_arb_ctrl: behavioural shift unit plus a scoreboard of expected completions.
module tb_shift_arb_ctrl;

  localparam int IW = 8;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          RST;
  logic          REQ0, REQ1;
  logic [1:0]    FUN0, FUN1;
  logic [IW-1:0] A0, B0, A1, B1;
  logic          GNT0, GNT1, DONE0, DONE1, ERR, BUSY, SU_EN;
  logic [OW-1:0] RESULT;
  logic [IW-1:0] SU_A, SU_B;
  logic [1:0]    SU_FUN;
  logic [OW-1:0] SU_OUT  = '0;
  logic          SU_FLAG = 1'b0;
  logic          sf_block = 1'b0;

  typedef struct {
    logic          id;
    logic [OW-1:0] res;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;
  logic mon_en       = 1'b0;

  shift_arb_ctrl #(.in_width(IW), .out_width(OW), .TIMEOUT(4)) dut (
    .clk(clk), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1), .FUN0(FUN0), .FUN1(FUN1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .RESULT(RESULT), .ERR(ERR), .BUSY(BUSY),
    .SU_A(SU_A), .SU_B(SU_B), .SU_FUN(SU_FUN), .SU_EN(SU_EN),
    .SU_OUT(SU_OUT), .SU_FLAG(SU_FLAG)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] shift_ref(input logic [1:0] fun,
                                              input logic [IW-1:0] a,
                                              input logic [IW-1:0] b);
    logic [OW-1:0] op;
    op = fun[1] ? OW'(b) : OW'(a);
    return fun[0] ? (op << 1) : (op >> 1);
  endfunction

  // Shift unit: result and valid flag registered one cycle after SU_EN.
  always @(posedge clk) begin
    if (SU_EN) SU_OUT <= shift_ref(SU_FUN, SU_A, SU_B);
    SU_FLAG <= SU_EN & ~sf_block;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic [OW-1:0] res, input logic err);
    exp_t e;
    e.id = id; e.res = res; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    step();
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      step();
      if (DONE0 || DONE1) begin
        cyc = k;
        break;
      end
    end
  endtask

  // Scoreboard and invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("gnt_exclusive", 32'(GNT0 & GNT1), 32'd0);
      check("done_exclusive", 32'(DONE0 & DONE1), 32'd0);
      if (DONE0 || DONE1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("done_id", 32'(DONE1), 32'(e.id));
          check("done_result", 32'(RESULT), 32'(e.res));
          check("done_err", 32'(ERR), 32'(e.err));
        end
      end else begin
        check("idle_result", 32'(RESULT), 32'd0);
        check("idle_err", 32'(ERR), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, g0, g1, d0, d1, gcount, dcount;
    int   dcyc[8];
    logic gid[8];

    RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
    FUN0 = '0; FUN1 = '0; A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    reset_dut();
    mon_en = 1'b1;

    // Reset state
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_gnt", 32'({GNT1, GNT0}), 32'd0);
    check("rst_done", 32'({DONE1, DONE0}), 32'd0);
    check("rst_su_en", 32'(SU_EN), 32'd0);
    check("rst_su_ops", 32'({SU_A, SU_B, SU_FUN}), 32'd0);

    // Single request: A0 << 1
    REQ0 = 1'b1; A0 = 8'h81; FUN0 = 2'b01; B0 = 8'h00;
    push(1'b0, 16'h0102, 1'b0);
    step();
    check("t1_gnt0", 32'(GNT0), 32'd1);
    check("t1_gnt1", 32'(GNT1), 32'd0);
    check("t1_su_en", 32'(SU_EN), 32'd1);
    check("t1_su_a", 32'(SU_A), 32'h81);
    check("t1_su_fun", 32'(SU_FUN), 32'h1);
    check("t1_busy", 32'(BUSY), 32'd1);
    REQ0 = 1'b0;
    step();
    check("t1_wait_su_en", 32'(SU_EN), 32'd0);
    check("t1_wait_su_ops", 32'({SU_A, SU_B, SU_FUN}), 32'd0);
    check("t1_wait_gnt0", 32'(GNT0), 32'd0);
    step();
    check("t1_done0", 32'(DONE0), 32'd1);
    check("t1_result", 32'(RESULT), 32'h0102);
    check("t1_err", 32'(ERR), 32'd0);
    step();
    check("t1_idle_busy", 32'(BUSY), 32'd0);
    check("t1_idle_done0", 32'(DONE0), 32'd0);

    // Simultaneous requests after reset: requester 0 first
    reset_dut();
    REQ0 = 1'b1; FUN0 = 2'b00; A0 = 8'h10; B0 = 8'h00;
    REQ1 = 1'b1; FUN1 = 2'b10; A1 = 8'h00; B1 = 8'h80;
    push(1'b0, 16'h0008, 1'b0);
    push(1'b1, 16'h0040, 1'b0);
    g0 = -1; g1 = -1; d0 = -1; d1 = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (GNT0) begin g0 = k; REQ0 = 1'b0; end
      if (GNT1) begin g1 = k; REQ1 = 1'b0; end
      if (DONE0) d0 = k;
      if (DONE1) d1 = k;
    end
    check("t2_gnt0_cycle", 32'(g0), 32'd1);
    check("t2_gnt1_cycle", 32'(g1), 32'd5);
    check("t2_done0_cycle", 32'(d0), 32'd3);
    check("t2_done_spacing", 32'(d1 - d0), 32'd4);

    // Sustained contention for 16 cycles: grants alternate starting with 0
    REQ0 = 1'b1; FUN0 = 2'b01; A0 = 8'h33;
    REQ1 = 1'b1; FUN1 = 2'b11; B1 = 8'hC1;
    for (int i = 0; i < 2; i++) begin
      push(1'b0, shift_ref(2'b01, 8'h33, 8'h00), 1'b0);
      push(1'b1, shift_ref(2'b11, 8'h00, 8'hC1), 1'b0);
    end
    gcount = 0; dcount = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if ((GNT0 || GNT1) && gcount < 8) begin gid[gcount] = GNT1; gcount++; end
      if ((DONE0 || DONE1) && dcount < 8) begin dcyc[dcount] = k; dcount++; end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    check("t3_grant_count", 32'(gcount), 32'd4);
    check("t3_done_count", 32'(dcount), 32'd4);
    for (int i = 0; i < 4 && i < gcount; i++)
      check("t3_grant_order", 32'(gid[i]), 32'(i % 2));
    if (dcount > 0) check("t3_first_done", 32'(dcyc[0]), 32'd3);
    for (int i = 1; i < 4 && i < dcount; i++)
      check("t3_done_spacing", 32'(dcyc[i] - dcyc[i-1]), 32'd4);
    step();
    step();

    // Timeout: shift unit never answers
    sf_block = 1'b1;
    REQ0 = 1'b1; FUN0 = 2'b00; A0 = 8'h55;
    push(1'b0, 16'h0000, 1'b1);
    step();
    check("t4_gnt0", 32'(GNT0), 32'd1);
    REQ0 = 1'b0;
    step();
    check("t4_wait_busy", 32'(BUSY), 32'd1);
    wait_done(10, cyc);
    check("t4_done_after_wait", 32'(cyc), 32'd4);
    check("t4_done0", 32'(DONE0), 32'd1);
    check("t4_err", 32'(ERR), 32'd1);
    check("t4_result", 32'(RESULT), 32'd0);
    step();
    check("t4_busy_after", 32'(BUSY), 32'd0);

    // Reset mid-WAIT aborts silently, then a REQ1-only request is served
    REQ0 = 1'b1; FUN0 = 2'b01; A0 = 8'h0F;
    step();
    REQ0 = 1'b0;
    step();
    step();
    check("t5_in_wait", 32'(BUSY), 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t5_busy", 32'(BUSY), 32'd0);
    check("t5_pulses", 32'({GNT1, GNT0, DONE1, DONE0, ERR, SU_EN}), 32'd0);
    check("t5_result", 32'(RESULT), 32'd0);
    check("t5_su_ops", 32'({SU_A, SU_B, SU_FUN}), 32'd0);
    sf_block = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_no_done", 32'({DONE1, DONE0, ERR}), 32'd0);
    end
    REQ1 = 1'b1; FUN1 = 2'b01; A1 = 8'hF0; B1 = 8'h00;
    push(1'b1, 16'h01E0, 1'b0);
    step();
    check("t5_gnt1", 32'({GNT1, GNT0}), 32'b10);
    REQ1 = 1'b0;
    wait_done(10, cyc);
    check("t5_done1_latency", 32'(cyc), 32'd2);
    step();

    // REQ1 raised during requester 0's WAIT waits for the IDLE cycle after DONE0
    REQ0 = 1'b1; FUN0 = 2'b01; A0 = 8'h02;
    push(1'b0, 16'h0004, 1'b0);
    push(1'b1, shift_ref(2'b00, 8'h7E, 8'h00), 1'b0);
    g0 = -1; g1 = -1; d0 = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (GNT0) begin g0 = k; REQ0 = 1'b0; end
      if (GNT1) begin g1 = k; REQ1 = 1'b0; end
      if (DONE0) d0 = k;
      if (k == 2) begin REQ1 = 1'b1; FUN1 = 2'b00; A1 = 8'h7E; end
    end
    check("t6_gnt0_cycle", 32'(g0), 32'd1);
    check("t6_done0_cycle", 32'(d0), 32'd3);
    check("t6_gnt1_cycle", 32'(g1), 32'd5);

    step();
    step();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
